// File: rtl/tblink_rpc_invoke_sched.sv
// Invoke scheduler: round-robin arbitration of requester BFMs onto one invoke
// channel, with call-id slot tracking so blocking calls can be completed.

module tblink_rpc_invoke_slot #(
    parameter int RW    = 2,
    parameter int SEQ_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             alloc,
    input  logic             free,
    input  logic [RW-1:0]    alloc_owner,
    input  logic [SEQ_W-1:0] alloc_seq,
    output logic             busy,
    output logic [RW-1:0]    owner,
    output logic [SEQ_W-1:0] seq
);
    // Alloc wins over free so a slot released this cycle is handed straight on.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy  <= 1'b0;
            owner <= '0;
            seq   <= '0;
        end else if (alloc) begin
            busy  <= 1'b1;
            owner <= alloc_owner;
            seq   <= alloc_seq;
        end else if (free) begin
            busy <= 1'b0;
        end
    end
endmodule

module tblink_rpc_invoke_sched #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_OUT  = 4,
    parameter int METHOD_W = 16,
    parameter int DATA_W   = 64
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_blocking,
    input  logic [NUM_REQ*METHOD_W-1:0] req_method,
    input  logic [NUM_REQ*DATA_W-1:0]   req_params,
    output logic                        inv_valid,
    input  logic                        inv_ready,
    output logic [7:0]                  inv_call_id,
    output logic [METHOD_W-1:0]         inv_method,
    output logic [DATA_W-1:0]           inv_params,
    output logic                        inv_blocking,
    input  logic                        rsp_valid,
    input  logic [7:0]                  rsp_call_id,
    input  logic [DATA_W-1:0]           rsp_data,
    output logic [NUM_REQ-1:0]          done_valid,
    output logic [DATA_W-1:0]           done_data,
    output logic [$clog2(MAX_OUT):0]    outstanding,
    output logic                        err_unknown_rsp
);
    localparam int L      = $clog2(MAX_OUT);
    localparam int SEQ_W  = 8 - L;
    localparam int SLOT_W = (L > 0) ? L : 1;
    localparam int RW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int OW     = L + 1;

    typedef struct packed {
        logic                blocking;
        logic [METHOD_W-1:0] method;
        logic [DATA_W-1:0]   params;
    } req_t;

    req_t [NUM_REQ-1:0] reqs;

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
        assign reqs[r] = {req_blocking[r], req_method[r*METHOD_W +: METHOD_W],
                          req_params[r*DATA_W +: DATA_W]};
    end

    // Output stage and bookkeeping state
    req_t               stage_q;
    logic               inv_valid_q;
    logic [7:0]         call_id_q;
    logic [SEQ_W-1:0]   seq_q;
    logic [RW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] req_busy;
    logic [OW-1:0]      outstanding_q;
    logic [NUM_REQ-1:0] done_valid_q;
    logic [DATA_W-1:0]  done_data_q;
    logic               err_q;

    logic                          fire, load_en, accept, alloc, grant_any, any_free, rsp_hit;
    logic [RW-1:0]                 grant_idx, rsp_owner;
    logic [NUM_REQ-1:0]            elig;
    logic [SEQ_W-1:0]              seq_issue, rsp_seq;
    logic [SLOT_W-1:0]             rsp_slot, free_idx;
    logic [7:0]                    call_id_new;
    logic [MAX_OUT-1:0]            slot_busy, slot_rel, slot_alloc;
    logic [MAX_OUT-1:0][RW-1:0]    slot_owner;
    logic [MAX_OUT-1:0][SEQ_W-1:0] slot_seq;

    assign fire    = inv_valid_q && inv_ready;
    assign load_en = !inv_valid_q || inv_ready;
    // The invoke loaded now is the next one to transfer, so it takes the
    // sequence value the counter will hold after any transfer this cycle.
    assign seq_issue = seq_q + SEQ_W'(fire);

    if (L > 0) begin : g_slot_bits
        assign rsp_slot    = rsp_call_id[L-1:0];
        assign rsp_seq     = rsp_call_id[7:L];
        assign call_id_new = {seq_issue, {SLOT_W{alloc}} & free_idx};
    end else begin : g_no_slot_bits
        assign rsp_slot    = '0;
        assign rsp_seq     = rsp_call_id;
        assign call_id_new = seq_issue;
    end

    assign rsp_hit   = rsp_valid && slot_busy[rsp_slot] && (slot_seq[rsp_slot] == rsp_seq);
    assign rsp_owner = slot_owner[rsp_slot];

    // Lowest free slot, treating a slot released by this cycle's response as free.
    always_comb begin
        slot_rel = '0;
        free_idx = '0;
        any_free = 1'b0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            slot_rel[i] = rsp_hit && (rsp_slot == SLOT_W'(i));
            if (!slot_busy[i] || slot_rel[i]) begin
                any_free = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        elig = '0;
        for (int r = 0; r < NUM_REQ; r++)
            elig[r] = req_valid[r] && !req_busy[r] && (!req_blocking[r] || any_free);
    end

    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!grant_any && elig[idx]) begin
                grant_any = 1'b1;
                grant_idx = RW'(idx);
            end
        end
    end

    assign accept = reset_n && load_en && grant_any;
    assign alloc  = accept && reqs[grant_idx].blocking;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        slot_alloc = '0;
        for (int i = 0; i < MAX_OUT; i++)
            slot_alloc[i] = alloc && (free_idx == SLOT_W'(i));
    end

    for (genvar s = 0; s < MAX_OUT; s++) begin : g_slot
        tblink_rpc_invoke_slot #(.RW(RW), .SEQ_W(SEQ_W)) u_slot (
            .clock       (clock),
            .reset_n     (reset_n),
            .alloc       (slot_alloc[s]),
            .free        (slot_rel[s]),
            .alloc_owner (grant_idx),
            .alloc_seq   (seq_issue),
            .busy        (slot_busy[s]),
            .owner       (slot_owner[s]),
            .seq         (slot_seq[s])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inv_valid_q <= 1'b0;
            stage_q     <= '0;
            call_id_q   <= '0;
            seq_q       <= '0;
            rr_ptr      <= '0;
        end else begin
            if (accept) begin
                inv_valid_q <= 1'b1;
                stage_q     <= reqs[grant_idx];
                call_id_q   <= call_id_new;
                rr_ptr      <= (grant_idx == RW'(NUM_REQ - 1)) ? '0 : grant_idx + RW'(1);
            end else if (fire) begin
                inv_valid_q <= 1'b0;
            end
            if (fire) seq_q <= seq_q + SEQ_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_busy      <= '0;
            outstanding_q <= '0;
            done_valid_q  <= '0;
            done_data_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (alloc && grant_idx == RW'(r))
                    req_busy[r] <= 1'b1;
                else if (rsp_hit && rsp_owner == RW'(r))
                    req_busy[r] <= 1'b0;
            end
            if (alloc && !rsp_hit)
                outstanding_q <= outstanding_q + OW'(1);
            else if (!alloc && rsp_hit)
                outstanding_q <= outstanding_q - OW'(1);
            done_valid_q <= '0;
            if (rsp_hit) begin
                done_valid_q[rsp_owner] <= 1'b1;
                done_data_q             <= rsp_data;
            end
            err_q <= rsp_valid && !rsp_hit;
        end
    end

    assign inv_valid       = inv_valid_q;
    assign inv_call_id     = call_id_q;
    assign inv_method      = stage_q.method;
    assign inv_params      = stage_q.params;
    assign inv_blocking    = stage_q.blocking;
    assign done_valid      = done_valid_q;
    assign done_data       = done_data_q;
    assign outstanding     = outstanding_q;
    assign err_unknown_rsp = err_q;
endmodule

// File: tb/tb_tblink_rpc_invoke_sched.sv
// Directed bench for the invoke scheduler; five requesters so one can be
// starved while four blocking calls hold every slot.

module tb_tblink_rpc_invoke_sched;
    localparam int NR = 5;

    logic                clock = 1'b0;
    logic                reset_n;
    logic [NR-1:0]       req_valid, req_ready, req_blocking, done_valid;
    logic [NR-1:0][15:0] req_method;
    logic [NR-1:0][63:0] req_params;
    logic                inv_valid, inv_ready, inv_blocking, rsp_valid, err_unknown_rsp;
    logic [7:0]          inv_call_id, rsp_call_id;
    logic [15:0]         inv_method;
    logic [63:0]         inv_params, rsp_data, done_data;
    logic [2:0]          outstanding;

    int n_tests = 0;
    int n_fail  = 0;

    tblink_rpc_invoke_sched #(.NUM_REQ(NR), .MAX_OUT(4), .METHOD_W(16), .DATA_W(64)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_blocking    (req_blocking),
        .req_method      (req_method),
        .req_params      (req_params),
        .inv_valid       (inv_valid),
        .inv_ready       (inv_ready),
        .inv_call_id     (inv_call_id),
        .inv_method      (inv_method),
        .inv_params      (inv_params),
        .inv_blocking    (inv_blocking),
        .rsp_valid       (rsp_valid),
        .rsp_call_id     (rsp_call_id),
        .rsp_data        (rsp_data),
        .done_valid      (done_valid),
        .done_data       (done_data),
        .outstanding     (outstanding),
        .err_unknown_rsp (err_unknown_rsp)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle_inputs();
        req_valid    = '0;
        req_blocking = '0;
        rsp_valid    = 1'b0;
        rsp_call_id  = '0;
        rsp_data     = '0;
        inv_ready    = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic send_rsp(input logic [7:0] id, input logic [63:0] data);
        rsp_valid   = 1'b1;
        rsp_call_id = id;
        rsp_data    = data;
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin
            req_method[r] = 16'h0100 + 16'(r);
            req_params[r] = 64'hA0 + 64'(r);
        end
        idle_inputs();
        reset_n = 1'b0;

        // Reset state, with requests pending to show req_ready is held low
        req_valid = '1;
        tick();
        #1;
        chk("rst_req_ready",   req_ready, 0);
        chk("rst_inv_valid",   inv_valid, 0);
        chk("rst_call_id",     inv_call_id, 0);
        chk("rst_method",      inv_method, 0);
        chk("rst_params",      inv_params, 0);
        chk("rst_blocking",    inv_blocking, 0);
        chk("rst_done_valid",  done_valid, 0);
        chk("rst_done_data",   done_data, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err",         err_unknown_rsp, 0);
        do_reset();

        // Single blocking call and its completion
        req_method[0]   = 16'h0012;
        req_valid[0]    = 1'b1;
        req_blocking[0] = 1'b1;
        #1;
        chk("b1_req_ready", req_ready, 5'b00001);
        tick();
        req_valid = '0;
        #1;
        chk("b1_inv_valid",   inv_valid, 1);
        chk("b1_call_id",     inv_call_id, 8'h00);
        chk("b1_method",      inv_method, 16'h0012);
        chk("b1_blocking",    inv_blocking, 1);
        chk("b1_outstanding", outstanding, 1);
        tick();
        chk("b1_inv_drained", inv_valid, 0);
        send_rsp(8'h00, 64'hDEAD);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("b1_done_valid",  done_valid, 5'b00001);
        chk("b1_done_data",   done_data, 64'hDEAD);
        chk("b1_outstanding0", outstanding, 0);
        chk("b1_no_err",      err_unknown_rsp, 0);
        tick();
        chk("b1_done_pulse", done_valid, 0);
        req_method[0] = 16'h0100;

        // Round-robin over four non-blocking requesters
        do_reset();
        req_valid = 5'b01111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr_ready_%0d", k), req_ready, 64'(1) << (k % 4));
            tick();
            chk($sformatf("rr_call_id_%0d", k), inv_call_id, 64'(k * 4));
            chk($sformatf("rr_method_%0d", k), inv_method, 64'h100 + 64'(k % 4));
        end

        // Backpressure: stage holds the 0x10 invoke from requester 0
        inv_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_req_ready_%0d", c), req_ready, 0);
            chk($sformatf("bp_valid_%0d", c), inv_valid, 1);
            chk($sformatf("bp_call_id_%0d", c), inv_call_id, 8'h10);
            chk($sformatf("bp_method_%0d", c), inv_method, 16'h0100);
            chk($sformatf("bp_params_%0d", c), inv_params, 64'hA0);
            tick();
        end
        inv_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 5'b00010);
        tick();
        chk("bp_release_id",     inv_call_id, 8'h14);
        chk("bp_release_method", inv_method, 16'h0101);
        req_valid = '0;
        tick();
        chk("bp_drained", inv_valid, 0);

        // Fill all four slots, then starve requester 4
        do_reset();
        req_valid    = 5'b01111;
        req_blocking = 5'b11111;
        #1;
        chk("fill_ready_0", req_ready, 5'b00001);
        tick();
        chk("fill_ready_1", req_ready, 5'b00010);
        chk("fill_id_0",    inv_call_id, 8'h00);
        tick();
        chk("fill_ready_2", req_ready, 5'b00100);
        chk("fill_id_1",    inv_call_id, 8'h05);
        tick();
        chk("fill_ready_3", req_ready, 5'b01000);
        chk("fill_id_2",    inv_call_id, 8'h0A);
        tick();
        req_valid[4] = 1'b1;
        #1;
        chk("fill_id_3",       inv_call_id, 8'h0F);
        chk("stall_ready_a",   req_ready, 0);
        chk("stall_outstand",  outstanding, 4);
        tick();
        chk("stall_ready_b", req_ready, 0);
        tick();
        send_rsp(8'h05, 64'hBEEF);
        #1;
        chk("freed_same_cycle_ready", req_ready, 5'b10000);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("freed_done_valid",  done_valid, 5'b00010);
        chk("freed_done_data",   done_data, 64'hBEEF);
        chk("freed_outstanding", outstanding, 4);
        chk("freed_call_id",     inv_call_id, 8'h11);
        chk("freed_method",      inv_method, 16'h0104);
        chk("freed_blocking",    inv_blocking, 1);
        chk("freed_restall",     req_ready, 0);
        req_valid = '0;
        tick();

        // Stale sequence bits on a busy slot
        send_rsp(8'h04, 64'h5555);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("stale_err",         err_unknown_rsp, 1);
        chk("stale_outstanding", outstanding, 4);
        chk("stale_no_done",     done_valid, 0);
        tick();
        chk("stale_err_pulse", err_unknown_rsp, 0);
        send_rsp(8'h00, 64'h1234);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("match_done_valid",  done_valid, 5'b00001);
        chk("match_done_data",   done_data, 64'h1234);
        chk("match_no_err",      err_unknown_rsp, 0);
        chk("match_outstanding", outstanding, 3);

        // Reset with calls still outstanding: later responses are unknown
        do_reset();
        chk("midrst_outstanding", outstanding, 0);
        send_rsp(8'h0F, 64'h7777);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("midrst_err",         err_unknown_rsp, 1);
        chk("midrst_no_done",     done_valid, 0);
        chk("midrst_outstanding2", outstanding, 0);

        // Sequence wrap over 260 back-to-back non-blocking invokes
        do_reset();
        req_valid[0] = 1'b1;
        tick();
        for (int k = 0; k < 260; k++) begin
            chk($sformatf("wrap_id_%0d", k), inv_call_id, 64'((k % 64) * 4));
            tick();
        end
        chk("wrap_valid", inv_valid, 1);
        req_valid = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
